eu_operand_decode: RTL and testbench

EU_OPERAND_DECODE -- requirements
Module: eu_operand_decode

---
 rtl/eu_pkg.sv | 40 ++++
 rtl/eu_op_lut.sv | 27 ++
 rtl/eu_operand_decode.sv | 180 ++++++++++++++++++
 tb/tb_eu_operand_decode.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eu_pkg.sv
// Shared types and DSP control constants for the execution-unit operand decoder.
package eu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_MAC  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_PASS = 4'd7,
    OP_MACN = 4'd8
  } opcode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  localparam logic [6:0] OPMODE_ALU  = 7'b0110011;
  localparam logic [6:0] OPMODE_OR   = 7'b0111011;
  localparam logic [6:0] OPMODE_MUL  = 7'b0000101;
  localparam logic [6:0] OPMODE_MAC  = 7'b0100101;
  localparam logic [6:0] OPMODE_PASS = 7'b0000011;

  localparam logic [3:0] ALUMODE_ADD   = 4'b0000;
  localparam logic [3:0] ALUMODE_SUB   = 4'b0011;
  localparam logic [3:0] ALUMODE_LOGIC = 4'b1100;
  localparam logic [3:0] ALUMODE_XOR   = 4'b0100;

  // Control word produced by the opcode lookup; mul_fmt selects the
  // multiplier operand layout (A/B to the multiplier, C cleared).
  typedef struct packed {
    logic [6:0] opmode;
    logic [3:0] alumode;
    logic       mul_fmt;
  } ctrl_t;

endpackage

// File: rtl/eu_op_lut.sv
// Combinational opcode -> DSP control lookup. MACN maps to the MUL encoding
// (its first beat); illegal opcodes fall back to PASS.
module eu_op_lut
  import eu_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  // Opcode decode table
  always_comb begin
    ctrl = '{opmode: OPMODE_PASS, alumode: ALUMODE_ADD, mul_fmt: 1'b0};
    case (opcode)
      OP_ADD:  ctrl = '{opmode: OPMODE_ALU,  alumode: ALUMODE_ADD,   mul_fmt: 1'b0};
      OP_SUB:  ctrl = '{opmode: OPMODE_ALU,  alumode: ALUMODE_SUB,   mul_fmt: 1'b0};
      OP_MUL:  ctrl = '{opmode: OPMODE_MUL,  alumode: ALUMODE_ADD,   mul_fmt: 1'b1};
      OP_MAC:  ctrl = '{opmode: OPMODE_MAC,  alumode: ALUMODE_ADD,   mul_fmt: 1'b1};
      OP_AND:  ctrl = '{opmode: OPMODE_ALU,  alumode: ALUMODE_LOGIC, mul_fmt: 1'b0};
      OP_OR:   ctrl = '{opmode: OPMODE_OR,   alumode: ALUMODE_LOGIC, mul_fmt: 1'b0};
      OP_XOR:  ctrl = '{opmode: OPMODE_ALU,  alumode: ALUMODE_XOR,   mul_fmt: 1'b0};
      OP_PASS: ctrl = '{opmode: OPMODE_PASS, alumode: ALUMODE_ADD,   mul_fmt: 1'b0};
      OP_MACN: ctrl = '{opmode: OPMODE_MUL,  alumode: ALUMODE_ADD,   mul_fmt: 1'b1};
      default: ctrl = '{opmode: OPMODE_PASS, alumode: ALUMODE_ADD,   mul_fmt: 1'b0};
    endcase
  end

endmodule

// File: rtl/eu_operand_decode.sv
// Operand decoder feeding a DSP48-style execution unit. Registers one beat at
// a time behind a valid/ready skid-free output stage and sequences MACN bursts
// (one MUL beat followed by MAC beats).
// Optional macro IPPRO_OPCODE_ERR_EN: traps illegal opcodes into sticky out_err
// and drops the offending beat instead of decoding it as PASS.
module eu_operand_decode
  import eu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_opcode,
  input  logic signed [DATA_W-1:0] in_op_a,
  input  logic signed [DATA_W-1:0] in_op_b,
  input  logic [CNT_W-1:0]         in_count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [29:0]              out_a,
  output logic [17:0]              out_b,
  output logic [47:0]              out_c,
  output logic [6:0]               out_opmode,
  output logic [3:0]               out_alumode,
  output logic [4:0]               out_inmode,
  output logic [2:0]               out_carryinsel,
  output logic                     out_carryin,
  output logic                     out_last
`ifdef IPPRO_OPCODE_ERR_EN
  ,
  output logic                     out_err
`endif
);

  function automatic logic [29:0] sext30(input logic [DATA_W-1:0] v);
    return {{(30-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic [17:0] sext18(input logic [DATA_W-1:0] v);
    return {{(18-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic [47:0] sext48(input logic [DATA_W-1:0] v);
    return {{(48-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  ctrl_t            ctrl;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] first_rem;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [29:0]      a_q, a_d;
  logic [17:0]      b_q, b_d;
  logic [47:0]      c_q, c_d;
  logic [6:0]       opmode_q, opmode_d;
  logic [3:0]       alumode_q, alumode_d;
  logic             accept;
`ifdef IPPRO_OPCODE_ERR_EN
  logic             err_q, err_d;
  logic             illegal;

  assign illegal = (in_opcode > 4'd8);
`endif

  eu_op_lut u_lut (
    .opcode (in_opcode),
    .ctrl   (ctrl)
  );

  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  // A zero count is a one-beat burst, so nothing remains after the MUL beat.
  assign first_rem = (in_count == '0) ? '0 : in_count - CNT_W'(1);

  // Next-state: burst sequencing, handshake and operand formatting
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    valid_d   = valid_q;
    last_d    = last_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    opmode_d  = opmode_q;
    alumode_d = alumode_q;
`ifdef IPPRO_OPCODE_ERR_EN
    err_d     = err_q;
`endif
    if (out_ready) valid_d = 1'b0;
    if (accept) begin
      if (state_q == ST_ACCUM) begin
        // Burst continuation: opcode is ignored, always MAC
        valid_d   = 1'b1;
        a_d       = sext30(in_op_a);
        b_d       = sext18(in_op_b);
        c_d       = '0;
        opmode_d  = OPMODE_MAC;
        alumode_d = ALUMODE_ADD;
        rem_d     = rem_q - CNT_W'(1);
        last_d    = (rem_q == CNT_W'(1));
        if (rem_q == CNT_W'(1)) state_d = ST_IDLE;
      end
`ifdef IPPRO_OPCODE_ERR_EN
      else if (illegal) begin
        err_d   = 1'b1;
        valid_d = 1'b0;
      end
`endif
      else begin
        valid_d   = 1'b1;
        opmode_d  = ctrl.opmode;
        alumode_d = ctrl.alumode;
        last_d    = 1'b1;
        if (ctrl.mul_fmt) begin
          a_d = sext30(in_op_a);
          b_d = sext18(in_op_b);
          c_d = '0;
        end else begin
          {a_d, b_d} = sext48(in_op_b);
          c_d        = sext48(in_op_a);
        end
        if (in_opcode == OP_MACN && first_rem != '0) begin
          rem_d   = first_rem;
          state_d = ST_ACCUM;
          last_d  = 1'b0;
        end
      end
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      opmode_q  <= '0;
      alumode_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      opmode_q  <= opmode_d;
      alumode_q <= alumode_d;
    end
  end

`ifdef IPPRO_OPCODE_ERR_EN
  // Sticky illegal-opcode flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign out_err = err_q;
`endif

  assign out_valid      = valid_q;
  assign out_last       = last_q;
  assign out_a          = a_q;
  assign out_b          = b_q;
  assign out_c          = c_q;
  assign out_opmode     = opmode_q;
  assign out_alumode    = alumode_q;
  assign out_inmode     = '0;
  assign out_carryinsel = '0;
  assign out_carryin    = 1'b0;

endmodule

// File: tb/tb_eu_operand_decode.sv
// Testbench for eu_operand_decode: directed steps followed by random traffic,
// checked against a transaction-level reference model.
module tb_eu_operand_decode;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [DATA_W-1:0] in_op_a, in_op_b;
  logic [CNT_W-1:0]  in_count;
  logic              out_valid;
  logic              out_ready;
  logic [29:0]       out_a;
  logic [17:0]       out_b;
  logic [47:0]       out_c;
  logic [6:0]        out_opmode;
  logic [3:0]        out_alumode;
  logic [4:0]        out_inmode;
  logic [2:0]        out_carryinsel;
  logic              out_carryin;
  logic              out_last;
`ifdef IPPRO_OPCODE_ERR_EN
  logic              out_err;
`endif

  eu_operand_decode #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_opcode      (in_opcode),
    .in_op_a        (in_op_a),
    .in_op_b        (in_op_b),
    .in_count       (in_count),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_a          (out_a),
    .out_b          (out_b),
    .out_c          (out_c),
    .out_opmode     (out_opmode),
    .out_alumode    (out_alumode),
    .out_inmode     (out_inmode),
    .out_carryinsel (out_carryinsel),
    .out_carryin    (out_carryin),
    .out_last       (out_last)
`ifdef IPPRO_OPCODE_ERR_EN
    ,
    .out_err        (out_err)
`endif
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: the transaction currently presented on the output port
  bit          m_valid;
  logic [29:0] m_a;
  logic [17:0] m_b;
  logic [47:0] m_c;
  logic [6:0]  m_opm;
  logic [3:0]  m_alu;
  bit          m_last;
  int          m_left;   // MAC beats still owed by the current MACN burst
  bit          m_err;

  logic [6:0] opm_tab [0:7];
  logic [3:0] alu_tab [0:7];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_a = '0; m_b = '0; m_c = '0; m_opm = '0; m_alu = '0;
    m_last = 0; m_left = 0; m_err = 0;
  endtask

  task automatic model_accept(input logic [3:0] op, input logic [DATA_W-1:0] a,
                              input logic [DATA_W-1:0] b, input logic [CNT_W-1:0] cnt);
    longint sa, sb;
    logic [47:0] wide_b;
    int n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (m_left > 0 || op == 4'd2 || op == 4'd3 || op == 4'd8) begin
      m_a = sa[29:0]; m_b = sb[17:0]; m_c = 48'd0; m_alu = 4'b0000;
    end else begin
      wide_b = sb[47:0];
      m_a = wide_b[47:18]; m_b = wide_b[17:0]; m_c = sa[47:0];
    end
    if (m_left > 0) begin
      m_opm = 7'b0100101; m_alu = 4'b0000;
      m_left--; m_last = (m_left == 0); m_valid = 1;
    end else if (op > 4'd8) begin
`ifdef IPPRO_OPCODE_ERR_EN
      m_err = 1;
      // dropped beat leaves previously registered data untouched
      m_valid = 0;
`else
      m_opm = 7'b0000011; m_alu = 4'b0000; m_last = 1; m_valid = 1;
`endif
    end else if (op == 4'd8) begin
      n = (cnt == 0) ? 1 : int'(cnt);
      m_opm = 7'b0000101; m_alu = 4'b0000;
      m_left = n - 1; m_last = (m_left == 0); m_valid = 1;
    end else begin
      m_opm = opm_tab[op]; m_alu = alu_tab[op]; m_last = 1; m_valid = 1;
    end
  endtask

  // Saved model data so a trapped beat can restore the held output fields
  logic [29:0] s_a; logic [17:0] s_b; logic [47:0] s_c;
  logic [6:0] s_opm; logic [3:0] s_alu; bit s_last;

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".ctrl0"}, 64'({out_inmode, out_carryinsel, out_carryin}), 64'd0);
`ifdef IPPRO_OPCODE_ERR_EN
    chk({tag, ".err"}, 64'(out_err), 64'(m_err));
`endif
    if (m_valid) begin
      chk({tag, ".a"},    64'(out_a),       64'(m_a));
      chk({tag, ".b"},    64'(out_b),       64'(m_b));
      chk({tag, ".c"},    64'(out_c),       64'(m_c));
      chk({tag, ".opm"},  64'(out_opmode),  64'(m_opm));
      chk({tag, ".alu"},  64'(out_alumode), 64'(m_alu));
      chk({tag, ".last"}, 64'(out_last),    64'(m_last));
    end
  endtask

  // One clock: drive at negedge, check, advance the model, wait next negedge
  task automatic step(input string tag, input bit v, input logic [3:0] op, input int a,
                      input int b, input int cnt, input bit ordy);
    bit rdy;
    in_valid = v; in_opcode = op; in_op_a = a[DATA_W-1:0]; in_op_b = b[DATA_W-1:0];
    in_count = cnt[CNT_W-1:0]; out_ready = ordy;
    #1;
    check_outputs(tag);
    rdy = !m_valid || ordy;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
    if (m_valid && ordy) m_valid = 0;
    if (v && rdy) begin
      s_a = m_a; s_b = m_b; s_c = m_c; s_opm = m_opm; s_alu = m_alu; s_last = m_last;
      model_accept(op, in_op_a, in_op_b, in_count);
      if (op > 4'd8 && !m_valid && m_err) begin
        m_a = s_a; m_b = s_b; m_c = s_c; m_opm = s_opm; m_alu = s_alu; m_last = s_last;
      end
    end
    @(negedge CLK);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid0"}, 64'(out_valid), 64'd0);
    chk({tag, ".last0"},  64'(out_last),  64'd0);
    chk({tag, ".data0"},  64'(|{out_a, out_b, out_c}), 64'd0);
    chk({tag, ".ctl0"},   64'({out_opmode, out_alumode, out_inmode, out_carryinsel, out_carryin}), 64'd0);
`ifdef IPPRO_OPCODE_ERR_EN
    chk({tag, ".err0"},   64'(out_err), 64'd0);
`endif
  endtask

  initial begin
    opm_tab = '{7'b0110011, 7'b0110011, 7'b0000101, 7'b0100101,
                7'b0110011, 7'b0111011, 7'b0110011, 7'b0000011};
    alu_tab = '{4'b0000, 4'b0011, 4'b0000, 4'b0000,
                4'b1100, 4'b1100, 4'b0100, 4'b0000};
    model_clear();
    in_valid = 0; in_opcode = '0; in_op_a = '0; in_op_b = '0; in_count = '0; out_ready = 0;
    RST_N = 0;
    repeat (3) @(negedge CLK);
    check_zero("reset");
    RST_N = 1;

    // ADD 5, -3
    step("add", 1, 4'd0, 5, -3, 0, 1);
    step("add_out", 0, 4'd0, 0, 0, 0, 1);
    chk("add.c_lit",  64'(out_c), 64'd5);
    chk("add.ab_lit", 64'({out_a, out_b}), 64'hFFFF_FFFF_FFFD);
    step("idle", 0, 4'd0, 0, 0, 0, 1);

    // MACN count=3
    step("macn3_0", 1, 4'd8, 7, -2, 3, 1);
    step("macn3_1", 1, 4'd1, -100, 300, 9, 1);
    step("macn3_2", 1, 4'd6, 32767, -32768, 0, 1);
    // next opcode must decode normally again (burst finished)
    step("macn3_3", 1, 4'd4, 12, 34, 0, 1);
    step("macn3_4", 0, 4'd0, 0, 0, 0, 1);

    // Back-pressure: 4 stalled cycles then release
    step("bp_0", 1, 4'd5, -1, 77, 0, 1);
    for (int i = 0; i < 4; i++) step("bp_stall", 1, 4'd6, 1234, -5678, 0, 0);
    step("bp_rel", 1, 4'd6, 1234, -5678, 0, 1);
    step("bp_done", 0, 4'd0, 0, 0, 0, 1);
    step("bp_idle", 0, 4'd0, 0, 0, 0, 1);

    // MACN count=0 -> single MUL, last=1
    step("macn0", 1, 4'd8, -9, 9, 0, 1);
    step("macn0_o", 1, 4'd0, 1, 1, 0, 1);
    step("macn0_i", 0, 4'd0, 0, 0, 0, 1);

    // Reset in the middle of a MACN count=4 burst
    step("macn4_0", 1, 4'd8, 3, 4, 4, 1);
    step("macn4_1", 1, 4'd0, 5, 6, 0, 1);
    in_valid = 0;
    #1 RST_N = 0;
    #1;
    model_clear();
    check_zero("midrst");
    #1 RST_N = 1;
    @(negedge CLK);
    step("post_rst_add", 1, 4'd0, 100, -1, 0, 1);
    step("post_rst_o", 0, 4'd0, 0, 0, 0, 1);

    // Illegal opcode 12
    step("ill12", 1, 4'd12, 44, 55, 0, 1);
    step("ill12_o", 0, 4'd0, 0, 0, 0, 1);
    step("ill12_h", 0, 4'd0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step("rnd", ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           int'($urandom), int'($urandom), int'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0));
    end
    step("rnd_drain", 0, 4'd0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
